// File: rtl/led_mode_scheduler.sv
// Time-multiplexes NUM_MODES LED pattern drivers onto one 8-bit LED bank, advancing on a debounced button.
// Optional AUTO_ADVANCE_EN adds a dwell timer that advances modes without user input.
module led_mode_scheduler #(
    parameter int unsigned NUM_MODES       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLANK_CYCLES    = 8,
    parameter int unsigned DWELL_CYCLES    = 4096,
    localparam int unsigned MODE_W         = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_next,
    input  logic [8*NUM_MODES-1:0] mode_led_in,
    output logic [NUM_MODES-1:0]   mode_rst_n,
    output logic [7:0]             led_out,
    output logic [MODE_W-1:0]      cur_mode,
    output logic                   busy
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLANK_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]           btn_sync;
    logic                 btn_s;
    logic [DB_W-1:0]      db_cnt;
    logic                 db_level;
    logic                 db_hit;
    logic                 press_evt;
    logic                 advance;
    logic [BLK_W-1:0]     blank_cnt;
    logic                 blank_last;
    logic [7:0]           led_sel;
    logic [NUM_MODES-1:0] mode_onehot;
    logic [7:0]           led_nxt;
    logic [NUM_MODES-1:0] mode_rst_n_nxt;
    logic                 busy_nxt;

    // Two-flop synchroniser for the raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_sync <= 2'b00;
        else        btn_sync <= {btn_sync[0], btn_next};
    end
    assign btn_s = btn_sync[1];

    // Debounce: level flips after DEBOUNCE_CYCLES consecutive differing samples
    assign db_hit = (btn_s != db_level) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= '0;
            db_level  <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            press_evt <= db_hit && btn_s;
            if (btn_s == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                db_level <= ~db_level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef AUTO_ADVANCE_EN
    localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_hit;

    assign dwell_hit = (state == ST_RUN) && (dwell_cnt == DWELL_LAST);
    assign advance   = press_evt || dwell_hit;

    // Dwell timer only counts inside RUN; a press restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         dwell_cnt <= '0;
        else if (state != ST_RUN || press_evt || dwell_hit) dwell_cnt <= '0;
        else                                                dwell_cnt <= dwell_cnt + 1'b1;
    end
`else
    logic dwell_unused;
    assign dwell_unused = (DWELL_CYCLES != 0);
    assign advance      = press_evt;
`endif

    assign blank_last = (blank_cnt == BLK_LAST);

    // Blank gap counter and mode index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt <= '0;
            cur_mode  <= '0;
        end else if (state == ST_BLANK) begin
            blank_cnt <= blank_last ? '0 : blank_cnt + 1'b1;
            if (blank_last) cur_mode <= (cur_mode == MODE_LAST) ? '0 : cur_mode + 1'b1;
        end else begin
            blank_cnt <= '0;
        end
    end

    // Pattern mux; unused encodings read as all-off
    always_comb begin
        led_sel = 8'h00;
        for (int unsigned k = 0; k < NUM_MODES; k++) begin
            if (cur_mode == MODE_W'(k)) led_sel = mode_led_in[8*k +: 8];
        end
    end

    assign mode_onehot = NUM_MODES'(1) << cur_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_START;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_START: state_nxt = ST_RUN;
            ST_RUN:   if (advance) state_nxt = ST_BLANK;
            ST_BLANK: if (blank_last) state_nxt = ST_START;
            default:  state_nxt = ST_START;
        endcase
    end

    always_comb begin
        led_nxt        = 8'h00;
        mode_rst_n_nxt = '0;
        busy_nxt       = 1'b1;
        case (state)
            ST_START: mode_rst_n_nxt = mode_onehot;
            ST_RUN: begin
                led_nxt        = led_sel;
                mode_rst_n_nxt = mode_onehot;
                busy_nxt       = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered LED, driver-reset and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out    <= 8'h00;
            mode_rst_n <= '0;
            busy       <= 1'b1;
        end else begin
            led_out    <= led_nxt;
            mode_rst_n <= mode_rst_n_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Scoreboard bench for led_mode_scheduler: expected mode entries are queued by stimulus, checked on each RUN entry.
module tb_led_mode_scheduler;

    localparam int unsigned NUM_MODES = 4;
    localparam int unsigned BLANK_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_next = 1'b0;
    logic [31:0] mode_led_in = 32'h08_04_02_01;
    logic [3:0]  mode_rst_n;
    logic [7:0]  led_out;
    logic [1:0]  cur_mode;
    logic        busy;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] rstn;
        logic [7:0] led;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    led_mode_scheduler #(
        .NUM_MODES      (NUM_MODES),
        .DEBOUNCE_CYCLES(16),
        .BLANK_CYCLES   (BLANK_CYC),
        .DWELL_CYCLES   (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_next   (btn_next),
        .mode_led_in(mode_led_in),
        .mode_rst_n (mode_rst_n),
        .led_out    (led_out),
        .cur_mode   (cur_mode),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int m);
        exp_t e;
        e.mode = 2'(m);
        e.rstn = 4'(1 << m);
        e.led  = 8'(1 << m);
        return e;
    endfunction

    // Monitor: compares on every RUN entry and measures each blank gap
    task automatic monitor();
        logic pb = 1'b1;
        int   zero_len = 0;
        logic led_bad = 1'b0;
        logic armed = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb = 1'b1; zero_len = 0; led_bad = 1'b0; armed = 1'b0;
                continue;
            end
            if (mode_rst_n == 4'b0000) begin
                zero_len++;
                if (led_out != 8'h00) led_bad = 1'b1;
            end else begin
                if (armed && zero_len > 0) begin
                    check("blank_len", 32'(zero_len), 32'(BLANK_CYC));
                    check("blank_led_off", 32'(led_bad), 32'(0));
                end
                armed = 1'b1; zero_len = 0; led_bad = 1'b0;
            end
            if (pb && !busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_run: mode %0d entered, none expected", cur_mode);
                end else begin
                    e = exp_q.pop_front();
                    check("run_cur_mode", 32'(cur_mode), 32'(e.mode));
                    check("run_mode_rst_n", 32'(mode_rst_n), 32'(e.rstn));
                    check("run_led_out", 32'(led_out), 32'(e.led));
                end
            end
            pb = busy;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold);
        btn_next = 1'b1;
        idle(hold);
        btn_next = 1'b0;
        idle(60);
    endtask

    task automatic wait_run(input string name);
        logic pb = busy;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (pb && !busy) return;
            pb = busy;
        end
        n_checks++; n_fail++;
        $display("FAIL %s: no RUN entry within 400 cycles", name);
    endtask

    // Counts cycles from RUN entry to the blank gap; optional press issued at press_at
    task automatic run_len(input int press_at, output int len);
        len = 0;
        while (len < 400 && mode_rst_n != 4'b0000) begin
            if (len == press_at) btn_next = 1'b1;
            @(negedge clk);
            len++;
        end
        btn_next = 1'b0;
    endtask

    initial begin
        int len;
        fork monitor(); join_none

        idle(3);
        check("rst_cur_mode", 32'(cur_mode), 32'(0));
        check("rst_led_out", 32'(led_out), 32'(0));
        check("rst_mode_rst_n", 32'(mode_rst_n), 32'(0));
        check("rst_busy", 32'(busy), 32'(1));
        exp_q.push_back(mk(0));

`ifdef AUTO_ADVANCE_EN
        exp_q.push_back(mk(1));
        exp_q.push_back(mk(2));
        exp_q.push_back(mk(3));
        rst_n = 1'b1;
        wait_run("auto_run0");
        run_len(-1, len);
        check("dwell_mode0", 32'(len), 32'(100));
        wait_run("auto_run1");
        run_len(30, len);
        check("press_in_dwell", 32'(len), 32'(50));
        wait_run("auto_run2");
        run_len(-1, len);
        check("dwell_restart", 32'(len), 32'(100));
        wait_run("auto_run3");
        idle(5);
`else
        rst_n = 1'b1;
        idle(20);
        check("run0_seen", 32'(exp_q.size()), 32'(0));

        // Short glitch must be filtered out
        btn_next = 1'b1;
        idle(5);
        btn_next = 1'b0;
        idle(60);
        check("glitch_cur_mode", 32'(cur_mode), 32'(0));
        check("glitch_led_out", 32'(led_out), 32'(8'h01));
        check("glitch_busy", 32'(busy), 32'(0));

        exp_q.push_back(mk(1));
        press(40);
        check("adv_to_1", 32'(exp_q.size()), 32'(0));
        exp_q.push_back(mk(2));
        press(25);
        exp_q.push_back(mk(3));
        press(25);
        exp_q.push_back(mk(0));
        press(25);
        check("wrap_cur_mode", 32'(cur_mode), 32'(0));
        check("wrap_mode_rst_n", 32'(mode_rst_n), 32'(4'b0001));

        // Long hold spans several mode windows yet advances once
        exp_q.push_back(mk(1));
        press(150);
        check("hold_cur_mode", 32'(cur_mode), 32'(1));

        exp_q.push_back(mk(2));
        press(25);
        btn_next = 1'b1;
        for (int n = 0; n < 100 && mode_rst_n != 4'b0000; n++) @(negedge clk);
        idle(3);
        btn_next = 1'b0;
        check("blank_before_rst", 32'(busy), 32'(1));
        check("blank_mode_before_rst", 32'(cur_mode), 32'(2));
        #2 rst_n = 1'b0;
        #1;
        check("midblank_cur_mode", 32'(cur_mode), 32'(0));
        check("midblank_led_out", 32'(led_out), 32'(0));
        check("midblank_mode_rst_n", 32'(mode_rst_n), 32'(0));
        check("midblank_busy", 32'(busy), 32'(1));
        exp_q.push_back(mk(0));
        idle(2);
        rst_n = 1'b1;
        idle(30);
`endif
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
